// File: rtl/seq_arith_serial_incr_sched.sv
// Round-robin scheduler sharing one bit-serial incrementer between two requesters.
// Optional overflow output is enabled with `define SERIAL_INCR_OVFL_EN.
module seq_arith_serial_incr_sched #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_val,
  output logic         req0_rdy,
  input  logic [W-1:0] req0_msg,
  input  logic         req1_val,
  output logic         req1_rdy,
  input  logic [W-1:0] req1_msg,
  output logic         resp_val,
  input  logic         resp_rdy,
  output logic [W-1:0] resp_msg,
  output logic         resp_id,
  output logic         busy
`ifdef SERIAL_INCR_OVFL_EN
  ,
  output logic         resp_ovfl
`endif
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         r_state;
  logic           r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_shreg;
  logic [W-1:0]   r_result;
  logic           r_carry;
  logic           r_id;
`ifdef SERIAL_INCR_OVFL_EN
  logic           r_ovfl;
`endif

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_sum;
  logic w_carry_next;

  // Pointer side wins on contention; rdy is only ever raised for the granted side.
  assign w_idle   = (r_state == StIdle);
  assign w_grant0 = w_idle && req0_val && (!r_ptr || !req1_val);
  assign w_grant1 = w_idle && req1_val && (r_ptr || !req0_val);

  assign w_sum        = r_shreg[0] ^ r_carry;
  assign w_carry_next = r_shreg[0] & r_carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_ptr    <= 1'b0;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_id     <= 1'b0;
`ifdef SERIAL_INCR_OVFL_EN
      r_ovfl   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant0 || w_grant1) begin
            r_shreg <= w_grant0 ? req0_msg : req1_msg;
            r_id    <= w_grant1;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_ptr   <= w_grant0;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          // Sum bits enter at the MSB so the LSB-first stream lands in order after W shifts.
          r_shreg  <= r_shreg >> 1;
          r_result <= {w_sum, r_result[W-1:1]};
          r_carry  <= w_carry_next;
          if (r_cnt == CW'(W - 1)) begin
            r_cnt   <= '0;
            r_state <= StDone;
`ifdef SERIAL_INCR_OVFL_EN
            r_ovfl  <= w_carry_next;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          if (resp_rdy) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req0_rdy = w_grant0;
  assign req1_rdy = w_grant1;
  assign resp_val = (r_state == StDone);
  assign busy     = (r_state != StIdle);
  assign resp_msg = r_result;
  assign resp_id  = r_id;
`ifdef SERIAL_INCR_OVFL_EN
  assign resp_ovfl = r_ovfl;
`endif

endmodule

// File: tb/tb_seq_arith_serial_incr_sched.sv
// Randomized bench for seq_arith_serial_incr_sched against a transaction-level model.
module tb_seq_arith_serial_incr_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_val, req1_val, resp_rdy;
  logic [W-1:0] req0_msg, req1_msg;
  logic         req0_rdy, req1_rdy, resp_val, resp_id, busy;
  logic [W-1:0] resp_msg;
`ifdef SERIAL_INCR_OVFL_EN
  logic         resp_ovfl;
`endif

  always #5 clk = ~clk;

  seq_arith_serial_incr_sched #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0_val (req0_val),
    .req0_rdy (req0_rdy),
    .req0_msg (req0_msg),
    .req1_val (req1_val),
    .req1_rdy (req1_rdy),
    .req1_msg (req1_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg),
    .resp_id  (resp_id),
    .busy     (busy)
`ifdef SERIAL_INCR_OVFL_EN
    ,
    .resp_ovfl(resp_ovfl)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: idle/waiting/holding a result, with a countdown of W edges after accept.
  bit m_idle = 1'b1;
  bit m_done = 1'b0;
  int m_left = 0;
  bit m_ptr  = 1'b0;
  int m_msg  = 0;
  bit m_id   = 1'b0;
  bit m_ovf  = 1'b0;
  int m_acc  = 0;
  int m_resp = 0;
  int d_acc  = 0;
  int d_resp = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs are already driven; check this cycle's outputs, advance the model, cross the edge.
  task automatic cycle();
    bit e0, e1;
    int op;
    #1;
    e0 = m_idle && req0_val && (!m_ptr || !req1_val);
    e1 = m_idle && req1_val && (m_ptr || !req0_val);
    check_eq("req0_rdy", {31'b0, req0_rdy}, {31'b0, e0});
    check_eq("req1_rdy", {31'b0, req1_rdy}, {31'b0, e1});
    check_eq("rdy_excl", {31'b0, req0_rdy && req1_rdy}, 32'd0);
    check_eq("resp_val", {31'b0, resp_val}, {31'b0, m_done});
    check_eq("busy", {31'b0, busy}, {31'b0, !m_idle});
    if (m_done) begin
      check_eq("resp_msg", {28'b0, resp_msg}, m_msg);
      check_eq("resp_id", {31'b0, resp_id}, {31'b0, m_id});
`ifdef SERIAL_INCR_OVFL_EN
      check_eq("resp_ovfl", {31'b0, resp_ovfl}, {31'b0, m_ovf});
`endif
    end
    if (!reset) begin
      if ((req0_val && req0_rdy) || (req1_val && req1_rdy)) d_acc++;
      if (resp_val && resp_rdy) d_resp++;
    end
    if (reset) begin
      m_idle = 1'b1; m_done = 1'b0; m_left = 0; m_ptr = 1'b0;
    end else if (m_idle) begin
      if (e0 || e1) begin
        op     = e0 ? int'(req0_msg) : int'(req1_msg);
        m_msg  = (op + 1) % (1 << W);
        m_ovf  = (op == (1 << W) - 1);
        m_id   = e1;
        m_ptr  = e0;
        m_left = W;
        m_idle = 1'b0;
        m_acc++;
      end
    end else if (!m_done) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (resp_rdy) begin
      m_done = 1'b0;
      m_idle = 1'b1;
      m_resp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0; resp_rdy = 1'b1;
    req0_msg = '0; req1_msg = '0;
    @(posedge clk); #1;
    run(2);
    reset = 1'b0;
    #1;
    check_eq("rst_msg", {28'b0, resp_msg}, 32'd0);
    check_eq("rst_id", {31'b0, resp_id}, 32'd0);
    check_eq("rst_val", {31'b0, resp_val}, 32'd0);
`ifdef SERIAL_INCR_OVFL_EN
    check_eq("rst_ovfl", {31'b0, resp_ovfl}, 32'd0);
`endif

    // Single request 0101 -> 0110
    req0_val = 1'b1; req0_msg = 4'b0101;
    cycle();
    req0_val = 1'b0;
    run(W + 3);

    // Wrap and non-wrap from requester 1
    req1_val = 1'b1; req1_msg = 4'hF;
    cycle();
    req1_val = 1'b0;
    run(W + 3);
    req1_val = 1'b1; req1_msg = 4'h7;
    cycle();
    req1_val = 1'b0;
    run(W + 3);

    // Contention: alternating grants
    req0_val = 1'b1; req0_msg = 4'h1; req1_val = 1'b1; req1_msg = 4'h9;
    run(5 * (W + 2));
    req0_val = 1'b0; req1_val = 1'b0;
    run(W + 3);

    // Back-pressure held for 10 cycles in DONE
    resp_rdy = 1'b0; req0_val = 1'b1; req0_msg = 4'h3;
    cycle();
    run(W + 10);
    resp_rdy = 1'b1;
    run(3);
    req0_val = 1'b0;
    run(W + 3);

    // Reset in the middle of CALC
    req0_val = 1'b1; req0_msg = 4'hA;
    cycle();
    req0_val = 1'b0;
    run(2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(W + 2);
    req1_val = 1'b1; req1_msg = 4'h3;
    cycle();
    req1_val = 1'b0;
    run(W + 3);

    // Random sweep over all operand values
    for (int i = 0; i < 1500; i++) begin
      req0_val = ($urandom_range(0, 2) != 0);
      req1_val = ($urandom_range(0, 2) != 0);
      req0_msg = W'(i);
      req1_msg = W'($urandom);
      resp_rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req0_val = 1'b0; req1_val = 1'b0; resp_rdy = 1'b1;
    run(W + 4);

    check_eq("accept_count", d_acc, m_acc);
    check_eq("resp_count", d_resp, m_resp);
    check_eq("drained", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
